// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO word receiver.
// Combinational definitions only; no timing or backpressure of its own.
package sipo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_word_receiver_if.sv
// Serial input plus parallel valid/ready output bundle of the word receiver.
// Receiver side is the slave modport; the driving/consuming side is the master.
interface sipo_word_receiver_if #(
  parameter int WIDTH = 8
);

  logic             si;
  logic             si_valid;
  logic             sof;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             frame_err;
  logic             overrun;

  modport slave (
    input  si, si_valid, sof, po_ready,
    output po, po_valid, frame_err, overrun
  );

  modport master (
    output si, si_valid, sof, po_ready,
    input  po, po_valid, frame_err, overrun
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// Shift-left register: load-first-bit, shift enable and clear; next value exposed.
// One cycle to update q; word_nxt is combinational and never stalls.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_first,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_nxt
);

  logic [WIDTH-1:0] q;

  always_comb begin
    word_nxt = q;
    if (load_first)
      word_nxt = {{(WIDTH-1){1'b0}}, bit_in};
    else if (shift_en)
      word_nxt = {q[WIDTH-2:0], bit_in};
  end

  // Clear wins so a completed word does not linger after it is handed off.
  always_ff @(posedge clk) begin
    if (reset || clr)
      q <= '0;
    else
      q <= word_nxt;
  end

endmodule

// File: rtl/sipo_word_receiver.sv
// Rebuilds MSB-first framed words into a one-entry valid/ready buffer; PO updates on the last-bit edge.
// Full buffer without same-cycle drain drops the new word and sets sticky overrun.
module sipo_word_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  sipo_word_receiver_if.slave bus
);

  localparam int               CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [0:0]       S_IDLE   = IDLE;
  localparam logic [0:0]       S_SHIFT  = SHIFT;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word_nxt;
  logic             in_shift;
  logic             load_first;
  logic             shift_en;
  logic             word_done;
  logic             accept;

  assign in_shift   = (state == S_SHIFT);
  assign load_first = bus.si_valid && bus.sof;
  assign shift_en   = bus.si_valid && !bus.sof && in_shift;
  assign word_done  = shift_en && (cnt == LAST_CNT);
  assign accept     = bus.po_valid && bus.po_ready;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .clr        (word_done),
    .load_first (load_first),
    .shift_en   (shift_en),
    .bit_in     (bus.si),
    .word_nxt   (word_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      if (load_first) begin
        // A SOF inside a word abandons the partial word and restarts on this bit.
        bus.frame_err <= in_shift;
        state         <= S_SHIFT;
        cnt           <= CW'(1);
      end else if (word_done) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (shift_en) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.po       <= '0;
      bus.po_valid <= 1'b0;
      bus.overrun  <= 1'b0;
    end else if (word_done) begin
      if (!bus.po_valid || bus.po_ready) begin
        bus.po       <= word_nxt;
        bus.po_valid <= 1'b1;
      end else begin
        bus.overrun <= 1'b1;
      end
    end else if (accept) begin
      bus.po_valid <= 1'b0;
    end
  end

endmodule
